fft_result_mux: RTL
===================

// Module: fft_result_mux
// PURPOSE
//  Return path of the FFT size-select fabric. Captures the size code at start.
//  Waits for the matching engine (FFT8/16/32) to finish, then reads that engine's
//  result memory in order. Streams the bins out on a single valid/ready port.
//  Sits between the three FFT cores and the downstream consumer; mirrors the start-side demux.
// PARAMETERS
//  DATA_W        32    width of one result bin ({re[15:0], im[15:0]} by default)
//  TIMEOUT_CYC   1024  max cycles in WAIT_DONE before abort; must be >= 2
// PORTS
//  clk_i          in   1       clock; all logic on rising edge
//  rst_n_i        in   1       synchronous, active-low reset
//  start_i        in   1       start pulse; same strobe that drives the start demux
//  fft_select_i   in   2       size code (`START_FFT8/`START_FFT16/`START_FFT32)
//  done_fft8_i    in   1       FFT8 engine done pulse
//  done_fft16_i   in   1       FFT16 engine done pulse
//  done_fft32_i   in   1       FFT32 engine done pulse
//  rd_en_o        out  1       read strobe to the selected engine's result RAM
//  rd_addr_o      out  5       bin index read; engine returns data 1 cycle later
//  data_fft8_i    in   DATA_W  FFT8 result RAM read data
//  data_fft16_i   in   DATA_W  FFT16 result RAM read data
//  data_fft32_i   in   DATA_W  FFT32 result RAM read data
//  out_data_o     out  DATA_W  streamed bin
//  out_index_o    out  5       bin index of out_data_o
//  out_valid_o    out  1       out_data_o valid
//  out_ready_i    in   1       consumer accepts when valid & ready
//  out_last_o     out  1       high with the final bin (index N-1)
//  busy_o         out  1       high from accepted start until return to IDLE
//  done_o         out  1       1-cycle pulse after last bin handshake
//  err_o          out  1       1-cycle error pulse
//  err_code_o     out  2       01 bad select, 10 timeout, 11 start while busy; held until next err
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge):
//   - State goes to IDLE. Every output is 0.
//   - Internal sel, address and timeout counter are cleared.
//   - Reset mid-transfer drops the transfer silently: no done_o, no err_o.
//  FSM states: IDLE, WAIT_DONE, FETCH, HOLD.
//  IDLE:
//   - start_i with a valid code: latch sel and N (8/16/32), set busy_o, go to WAIT_DONE.
//   - start_i with code 2'b00/undefined: err_o=1, err_code_o=01, stay IDLE.
//  WAIT_DONE:
//   - Only the done of the latched engine counts. Other engines' dones are ignored.
//   - On done, clear the address and go to FETCH.
//   - The timeout counter increments every cycle. At TIMEOUT_CYC-1 with no done:
//     err_o=1, err_code_o=10, busy_o drops, go to IDLE.
//   - Done and timeout in the same cycle: done wins.
//  FETCH (1 cycle): rd_en_o=1, rd_addr_o=addr. Go to HOLD.
//  HOLD:
//   - On entry, capture the latched engine's data into out_data_o and set out_valid_o=1.
//   - out_index_o=addr; out_last_o=(addr==N-1).
//   - Data, index and last stay stable while valid & !ready.
//   - On handshake with addr<N-1: valid drops, addr++, go to FETCH.
//   - On handshake with addr==N-1: valid drops, done_o pulses next cycle, busy_o drops, go to IDLE.
//  Throughput: 1 bin per 2 cycles with ready held high.
//  Latency: done pulse -> first out_valid_o = 2 cycles.
//  start_i while busy_o=1: ignored. err_o pulse, err_code_o=11. The current transfer continues unaffected.
//  start_i in the same cycle as the done_o pulse: accepted (FSM is already IDLE).
//  rd_addr_o holds its last value when rd_en_o=0. The address never exceeds N-1.
// STRUCTURE
//  Shared constants in constants.vh:
//   - `START_FFT8/16/32, `HIGH/`LOW (existing).
//   - New: `FFT_N8/16/32 lengths, FSM state encodings, `ERR_* codes.
//  One sub-module: fft_result_sel. Purely combinational 3:1 DATA_W mux, keyed by latched sel.
//  The FSM, counters and output register live here.
// TESTING
//  1. sel=`START_FFT8, start; done_fft8 after 5 cycles; ready=1.
//     -> 8 bins, indices 0..7, last at 7, done_o once, busy 1->0.
//  2. sel=`START_FFT32, ready toggled 1/0 randomly.
//     -> 32 bins in order, data stable during stalls, no dup/drop.
//  3. sel=`START_FFT16, pulse done_fft8 and done_fft32 first.
//     -> ignored; streaming starts only after done_fft16.
//  4. TIMEOUT_CYC=16, no done. -> err_o at cycle 16 after start, code 10, IDLE, no out_valid.
//  5. start with sel=2'b00 -> err code 01, busy stays 0.
//     Start during a transfer -> code 11, transfer completes.
//  6. rst_n_i=0 at bin 3 of FFT16 -> next cycle all outputs 0.
//     A new FFT8 run then completes normally.

Source files
------------

// File: rtl/fft_result_mux_pkg.sv
// ============================================================================
// Module      : fft_result_mux_pkg
// Description : Shared size codes, FFT lengths, error codes and FSM encoding
//               for the FFT result-return path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_result_mux_pkg;

    // Size codes, identical to those used by the start-side demux
    localparam logic [1:0] START_FFT8  = 2'b01;
    localparam logic [1:0] START_FFT16 = 2'b10;
    localparam logic [1:0] START_FFT32 = 2'b11;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int FFT_N8  = 8;
    localparam int FFT_N16 = 16;
    localparam int FFT_N32 = 32;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BAD_SEL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_BUSY    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_FETCH     = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    function automatic logic sel_valid(input logic [1:0] sel);
        return (sel == START_FFT8) || (sel == START_FFT16) || (sel == START_FFT32);
    endfunction

    // Index of the final bin (N-1) for a size code
    function automatic logic [4:0] last_index(input logic [1:0] sel);
        logic [4:0] idx;
        idx = 5'd0;
        case (sel)
            START_FFT8:  idx = 5'(FFT_N8 - 1);
            START_FFT16: idx = 5'(FFT_N16 - 1);
            START_FFT32: idx = 5'(FFT_N32 - 1);
            default:     idx = 5'd0;
        endcase
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_result_sel.sv
// ============================================================================
// Module      : fft_result_sel
// Description : Combinational 3:1 result-data mux keyed by the latched size code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_result_sel
    import fft_result_mux_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] data_fft8,
    input  logic [DATA_W-1:0] data_fft16,
    input  logic [DATA_W-1:0] data_fft32,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        case (sel)
            START_FFT8:  data = data_fft8;
            START_FFT16: data = data_fft16;
            START_FFT32: data = data_fft32;
            default:     data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fft_result_mux.sv
// ============================================================================
// Module      : fft_result_mux
// Description : Waits for the selected FFT engine to finish, then reads its
//               result RAM bin by bin and streams the bins on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_result_mux
    import fft_result_mux_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [1:0]        fft_select_i,
    input  logic              done_fft8_i,
    input  logic              done_fft16_i,
    input  logic              done_fft32_i,
    output logic              rd_en_o,
    output logic [4:0]        rd_addr_o,
    input  logic [DATA_W-1:0] data_fft8_i,
    input  logic [DATA_W-1:0] data_fft16_i,
    input  logic [DATA_W-1:0] data_fft32_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [4:0]        out_index_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            next_state;
    logic [1:0]        sel;
    logic [4:0]        last_idx;
    logic [4:0]        addr;
    logic [CNT_W-1:0]  cnt;
    logic              hold_first;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] data_hold;
    logic              engine_done;
    logic              timeout_hit;
    logic              timeout_err;
    logic              busy_start;
    logic              handshake;
    logic              at_last;

    fft_result_sel #(
        .DATA_W (DATA_W)
    ) u_sel (
        .sel        (sel),
        .data_fft8  (data_fft8_i),
        .data_fft16 (data_fft16_i),
        .data_fft32 (data_fft32_i),
        .data       (sel_data)
    );

    always_comb begin
        engine_done = 1'b0;
        case (sel)
            START_FFT8:  engine_done = done_fft8_i;
            START_FFT16: engine_done = done_fft16_i;
            START_FFT32: engine_done = done_fft32_i;
            default:     engine_done = 1'b0;
        endcase
    end

    assign timeout_hit = (cnt == CNT_LAST);
    assign timeout_err = (state == ST_WAIT_DONE) && !engine_done && timeout_hit;
    assign busy_start  = start_i && (state != ST_IDLE);
    assign handshake   = (state == ST_HOLD) && out_valid_o && out_ready_i;
    assign at_last     = (addr == last_idx);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_i && sel_valid(fft_select_i)) begin
                    next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (engine_done) begin
                    next_state = ST_FETCH;
                end else if (timeout_hit) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake) begin
                    next_state = at_last ? ST_IDLE : ST_FETCH;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sel         <= 2'b00;
            last_idx    <= 5'd0;
            addr        <= 5'd0;
            cnt         <= '0;
            hold_first  <= 1'b0;
            data_hold   <= '0;
            out_index_o <= 5'd0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
        end else begin
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            hold_first <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (sel_valid(fft_select_i)) begin
                            sel      <= fft_select_i;
                            last_idx <= last_index(fft_select_i);
                            cnt      <= '0;
                        end else begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_BAD_SEL;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    cnt <= cnt + 1'b1;
                    if (engine_done) begin
                        addr <= 5'd0;
                    end
                end
                ST_FETCH: begin
                    out_valid_o <= 1'b1;
                    out_index_o <= addr;
                    out_last_o  <= at_last;
                    hold_first  <= 1'b1;
                end
                ST_HOLD: begin
                    // RAM data lands in the first HOLD cycle; freeze it for any stall
                    if (hold_first) begin
                        data_hold <= sel_data;
                    end
                    if (handshake) begin
                        out_valid_o <= 1'b0;
                        out_last_o  <= 1'b0;
                        if (at_last) begin
                            done_o <= 1'b1;
                        end else begin
                            addr <= addr + 5'd1;
                        end
                    end
                end
                default: ;
            endcase

            if (timeout_err) begin
                err_o      <= 1'b1;
                err_code_o <= ERR_TIMEOUT;
            end else if (busy_start) begin
                err_o      <= 1'b1;
                err_code_o <= ERR_BUSY;
            end
        end
    end

    assign rd_en_o    = (state == ST_FETCH);
    assign rd_addr_o  = addr;
    assign busy_o     = (state != ST_IDLE);
    assign out_data_o = hold_first ? sel_data : data_hold;

endmodule

`default_nettype wire
